fetch_stage: RTL

Instruction-fetch stage of the 16-bit pipelined core. It owns the program counter and issues requests to instruction memory over a req/valid handshake. It buffers one returned instruction while the pipeline is stalled and drives the IF/ID pipeline register (`inst`, `PCPlus2`, `PCD`, `validD`) consumed by the decode stage. Redirects come from the execute stage; stall and flush come from the hazard unit.

---
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch for the 16-bit core: PC, one-entry hold buffer, IF/ID register.
// Define FETCH_BUBBLE_CNT_EN to add the saturating bubbleCount port.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        flushD,
    input  logic        PCSrcE,
    input  logic [15:0] PCTargetE,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemRdata,
    input  logic        imemValid,
    output logic [15:0] inst,
    output logic [15:0] PCPlus2,
    output logic [15:0] PCD,
    output logic        validD
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    output logic [31:0] bubbleCount
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetchState_t;

    fetchState_t state;
    fetchState_t stateNext;

    logic [15:0] pc;
    logic [15:0] pcNext;
    logic [15:0] bufInst;
    logic [15:0] bufPC;
    logic [15:0] redirPC;

    logic        holdIfId;
    logic        bufLoad;
    logic        redirLoad;
    logic        deliver;
    logic [15:0] delInst;
    logic [15:0] delPC;
    logic        loadBubble;

    assign holdIfId = stallF || flushD;

    // Request is gated by rst so nothing is outstanding while reset is held.
    assign imemReq  = !rst && (state != HOLD);
    assign imemAddr = pc;

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        bufLoad   = 1'b0;
        redirLoad = 1'b0;
        deliver   = 1'b0;
        delInst   = bufInst;
        delPC     = bufPC;
        unique case (state)
            FETCH: begin
                if (PCSrcE) begin
                    if (imemValid) begin
                        pcNext = PCTargetE;
                    end else begin
                        redirLoad = 1'b1;
                        stateNext = DRAIN;
                    end
                end else if (imemValid) begin
                    pcNext = pc + 16'd2;
                    if (holdIfId) begin
                        bufLoad   = 1'b1;
                        stateNext = HOLD;
                    end else begin
                        deliver = 1'b1;
                        delInst = imemRdata;
                        delPC   = pc;
                    end
                end
            end
            DRAIN: begin
                if (imemValid) begin
                    pcNext    = PCSrcE ? PCTargetE : redirPC;
                    stateNext = FETCH;
                end else if (PCSrcE) begin
                    redirLoad = 1'b1;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcNext    = PCTargetE;
                    stateNext = FETCH;
                end else if (!holdIfId) begin
                    deliver   = 1'b1;
                    stateNext = FETCH;
                end
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    // A bubble is loaded on flush, or whenever the register is free but empty-handed.
    assign loadBubble = flushD || (!stallF && !deliver);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            bufInst <= NOP_INST;
            bufPC   <= '0;
            redirPC <= '0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            if (bufLoad) begin
                bufInst <= imemRdata;
                bufPC   <= pc;
            end
            if (redirLoad) begin
                redirPC <= PCTargetE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst    <= NOP_INST;
            PCD     <= '0;
            PCPlus2 <= '0;
            validD  <= 1'b0;
        end else if (loadBubble) begin
            inst    <= NOP_INST;
            PCD     <= '0;
            PCPlus2 <= '0;
            validD  <= 1'b0;
        end else if (deliver) begin
            inst    <= delInst;
            PCD     <= delPC;
            PCPlus2 <= delPC + 16'd2;
            validD  <= 1'b1;
        end
    end

`ifdef FETCH_BUBBLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubbleCount <= '0;
        end else if (loadBubble && (bubbleCount != 32'hFFFF_FFFF)) begin
            bubbleCount <= bubbleCount + 32'd1;
        end
    end
`endif

endmodule
